mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single memory port of the AXI bridge (mem_access/mem_write/mem_size/mem_sel/mem_ready/mem_data) between the CPU's instruction-fetch port and data load/store port. It replaces the ad-hoc inst_miss toggle in the CPU top with an explicit grant state machine. The state machine registers the granted request, holds it stable until mem_ready, and routes the returned data to the correct requester. Flushed transactions are drained and their results discarded. The block also generates the stall requests for the IF and MEM stages.

Parameters:
STARVE_LIMIT, 4, maximum consecutive data grants while an instruction fetch is pending before the fetch is forced through.
REMAP_EN, 1, enables data-address remap from 0xBFAF_xxxx to 0x1FAF_xxxx.

Ports:
clk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
inst_req  in  1  fetch request; held until inst_ready
inst_addr  in  32  fetch address (PC)
inst_ready  out  1  one-cycle completion pulse for the fetch
inst_rdata  out  32  fetched word; valid while inst_ready=1
data_req  in  1  load/store request; held until data_ready
data_wr  in  1  1 = store, 0 = load
data_size  in  2  access size: 0 = byte, 1 = half, 2 = word
data_sel  in  4  byte strobes
data_addr  in  32  data address
data_wdata  in  32  store data
data_ready  out  1  one-cycle completion pulse for the data access
data_rdata  out  32  load data; valid while data_ready=1
flush  in  1  exception flush from the M stage
mem_access  out  1  request to the AXI bridge; level-held
mem_addr  out  32  address to the bridge
mem_write  out  1  write enable to the bridge
mem_size  out  2  access size to the bridge
mem_sel  out  4  byte strobes to the bridge
mem_st_data  out  32  store data to the bridge
mem_ready  in  1  bridge completion pulse
mem_data  in  32  bridge read data
stall_if  out  1  inst_req & ~inst_ready (combinational)
stall_mem  out  1  data_req & ~data_ready (combinational)

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - INST: fetch outstanding on the bridge.
  - DATA: data access outstanding on the bridge.
  - DROP: flushed transaction draining.
- Reset (aresetn=0 at posedge):
  - State goes to IDLE and starve_cnt to 0.
  - All outputs except stall_if/stall_mem reset to 0: mem_access, mem_write, inst_ready, data_ready, plus all address, data, size and sel registers.
- Eligibility in IDLE:
  - A requester is eligible when its req=1 and its ready output is 0 in that cycle. This masks a held request in the completion cycle.
  - A data request is not eligible while flush=1.
- Grant in IDLE:
  - Data wins, unless inst is eligible and starve_cnt == STARVE_LIMIT; then inst wins.
  - Inst wins when it is the only eligible requester.
- Registered outputs on grant: mem_addr, mem_write, mem_size, mem_sel and mem_st_data are loaded at the grant edge. mem_access=1 from the next cycle.
  - Inst grant loads: size 2, sel 4'b1111, write 0.
  - Data grant loads: the data_* fields. When REMAP_EN=1 and addr[31:16]==16'hBFAF, the upper half becomes 16'h1FAF.
- Starvation counter:
  - Increments on a data grant while inst was eligible.
  - Clears on any inst grant.
  - Saturates at STARVE_LIMIT.
- Holding: request fields and mem_access stay constant while in INST or DATA until mem_ready.
- Completion (INST or DATA with mem_ready=1, no flush):
  - mem_data is captured into inst_rdata or data_rdata.
  - The matching ready pulses for one cycle on the next cycle.
  - mem_access drops and state returns to IDLE.
  - Latency: grant edge N gives mem_access at N+1. mem_ready at cycle M gives ready at M+1. Earliest new grant is M+1, subject to the masking rule.
- Flush while in DATA or INST:
  - If mem_ready=1 in the same cycle: go to IDLE, no ready pulse.
  - Otherwise go to DROP with mem_access=0.
  - DROP waits for exactly one mem_ready, discards it, then returns to IDLE. The bridge always returns one mem_ready per transaction it has seen mem_access for.
  - flush in IDLE or DROP has no effect on state.
- Store completion: data_ready pulses; data_rdata is updated with mem_data and is don't-care to the requester.
- Reset mid-transaction: abandons immediately to IDLE. The bridge is reset by the same aresetn.
- mem_ready seen in IDLE is ignored.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; bridge mem_ready after 3 cycles with data 0x3C010000 -> mem_access for 3 cycles, mem_addr=0xBFC00000, mem_sel=4'hF, mem_write=0; inst_ready=1 with inst_rdata=0x3C010000 one cycle later; no second grant in the ready cycle.
- Simultaneous requests: inst_req and a data load at 0xBFAF8000 asserted together -> data granted first with mem_addr=0x1FAF8000, data_ready with the returned word, then the fetch granted.
- Starvation, STARVE_LIMIT=4: inst_req held while data_req is re-issued back to back -> exactly 4 data grants, then the fetch is granted, then starve_cnt=0.
- Store: data_wr=1, data_sel=4'b0011, data_size=1, data_wdata=0x0000BEEF, addr=0x00001000 -> mem_write=1, mem_sel=4'b0011, mem_size=1, mem_st_data=0x0000BEEF; one data_ready pulse.
- Flush mid-load: flush pulsed 1 cycle after grant, mem_ready 4 cycles later -> mem_access drops with flush, state goes to DROP, no data_ready; the next request is granted only after the drained mem_ready.
- Reset while in DATA: aresetn=0 for 1 cycle -> state IDLE, mem_access=0, starve_cnt=0, no ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU fetch/data ports, the arbiter and the AXI bridge port.
// The arbiter takes the slave view; the environment (CPU plus bridge) takes the master view.
interface mem_port_arbiter_if;
    // Instruction fetch port
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_rdata;
    // Data load/store port
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic [31:0] data_rdata;
    // Exception flush from the M stage
    logic        flush;
    // Bridge port
    logic        mem_access;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;
    // Pipeline stall requests
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_sel, data_addr,
               data_wdata, flush, mem_ready, mem_data,
        output inst_ready, inst_rdata, data_ready, data_rdata, mem_access, mem_addr,
               mem_write, mem_size, mem_sel, mem_st_data, stall_if, stall_mem
    );

    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_sel, data_addr,
               data_wdata, flush, mem_ready, mem_data,
        input  inst_ready, inst_rdata, data_ready, data_rdata, mem_access, mem_addr,
               mem_write, mem_size, mem_sel, mem_st_data, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single AXI-bridge memory port between instruction fetch and data access.
// One transaction is outstanding at a time; flushed transactions are drained and discarded.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          REMAP_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                aresetn,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StInst,
        StData,
        StDrop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            mem_access_q, mem_access_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic            mem_write_q, mem_write_d;
    logic [1:0]      mem_size_q, mem_size_d;
    logic [3:0]      mem_sel_q, mem_sel_d;
    logic [31:0]     mem_st_data_q, mem_st_data_d;
    logic            inst_ready_q, inst_ready_d;
    logic            data_ready_q, data_ready_d;
    logic [31:0]     inst_rdata_q, inst_rdata_d;
    logic [31:0]     data_rdata_q, data_rdata_d;

    logic            inst_elig;
    logic            data_elig;
    logic            grant_inst;
    logic            grant_data;
    logic [31:0]     data_addr_mapped;

    // Eligibility masks a request still held during its own completion cycle; data waits out a flush.
    always_comb begin
        inst_elig  = bus.inst_req & ~inst_ready_q;
        data_elig  = bus.data_req & ~data_ready_q & ~bus.flush;
        grant_inst = inst_elig & (~data_elig | (starve_q == CntMax));
        grant_data = data_elig & ~grant_inst;
    end

    // Kseg1 alias of the peripheral window folded onto its physical address.
    always_comb begin
        data_addr_mapped = bus.data_addr;
        if (REMAP_EN && (bus.data_addr[31:16] == 16'hBFAF)) begin
            data_addr_mapped = {16'h1FAF, bus.data_addr[15:0]};
        end
    end

    // Next-state: grant, hold until mem_ready, complete or drain on flush.
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        mem_access_d  = mem_access_q;
        mem_addr_d    = mem_addr_q;
        mem_write_d   = mem_write_q;
        mem_size_d    = mem_size_q;
        mem_sel_d     = mem_sel_q;
        mem_st_data_d = mem_st_data_q;
        inst_ready_d  = 1'b0;
        data_ready_d  = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_rdata_d  = data_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_inst) begin
                    state_d       = StInst;
                    starve_d      = '0;
                    mem_access_d  = 1'b1;
                    mem_addr_d    = bus.inst_addr;
                    mem_write_d   = 1'b0;
                    mem_size_d    = 2'd2;
                    mem_sel_d     = 4'b1111;
                    mem_st_data_d = '0;
                end else if (grant_data) begin
                    state_d       = StData;
                    mem_access_d  = 1'b1;
                    mem_addr_d    = data_addr_mapped;
                    mem_write_d   = bus.data_wr;
                    mem_size_d    = bus.data_size;
                    mem_sel_d     = bus.data_sel;
                    mem_st_data_d = bus.data_wdata;
                    if (inst_elig && (starve_q != CntMax)) begin
                        starve_d = starve_q + CntW'(1);
                    end
                end
            end
            StInst, StData: begin
                if (bus.flush) begin
                    // A reply arriving with the flush retires the transaction on the spot.
                    mem_access_d = 1'b0;
                    state_d      = bus.mem_ready ? StIdle : StDrop;
                end else if (bus.mem_ready) begin
                    mem_access_d = 1'b0;
                    state_d      = StIdle;
                    if (state_q == StInst) begin
                        inst_ready_d = 1'b1;
                        inst_rdata_d = bus.mem_data;
                    end else begin
                        data_ready_d = 1'b1;
                        data_rdata_d = bus.mem_data;
                    end
                end
            end
            StDrop: begin
                // The bridge still owes one reply for the flushed transaction.
                if (bus.mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d      = StIdle;
                mem_access_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            starve_q      <= '0;
            mem_access_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_write_q   <= 1'b0;
            mem_size_q    <= '0;
            mem_sel_q     <= '0;
            mem_st_data_q <= '0;
            inst_ready_q  <= 1'b0;
            data_ready_q  <= 1'b0;
            inst_rdata_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            mem_access_q  <= mem_access_d;
            mem_addr_q    <= mem_addr_d;
            mem_write_q   <= mem_write_d;
            mem_size_q    <= mem_size_d;
            mem_sel_q     <= mem_sel_d;
            mem_st_data_q <= mem_st_data_d;
            inst_ready_q  <= inst_ready_d;
            data_ready_q  <= data_ready_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    // Output drive; stalls are combinational so the pipeline sees them in the request cycle.
    always_comb begin
        bus.mem_access  = mem_access_q;
        bus.mem_addr    = mem_addr_q;
        bus.mem_write   = mem_write_q;
        bus.mem_size    = mem_size_q;
        bus.mem_sel     = mem_sel_q;
        bus.mem_st_data = mem_st_data_q;
        bus.inst_ready  = inst_ready_q;
        bus.inst_rdata  = inst_rdata_q;
        bus.data_ready  = data_ready_q;
        bus.data_rdata  = data_rdata_q;
        bus.stall_if    = bus.inst_req & ~inst_ready_q;
        bus.stall_mem   = bus.data_req & ~data_ready_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: CPU requesters and a bridge with random latency,
// compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;
    localparam int NCYC   = 3000;

    logic clk;
    logic aresetn;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT(STARVE),
        .REMAP_EN    (1'b1)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%08h, want 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: one outstanding transaction record plus the bus-facing registers.
    bit          m_busy;      // a granted transaction awaits its bridge reply
    bit          m_is_inst;   // outstanding transaction belongs to the fetch port
    bit          m_killed;    // outstanding transaction was flushed; its reply is thrown away
    int          m_waits;     // data grants handed out while the fetch waited, since last fetch grant
    logic        e_access, e_write, e_iready, e_dready;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [1:0]  e_size;
    logic [3:0]  e_sel;
    int          m_inst_done, m_data_done, dut_inst_done, dut_data_done;

    task automatic model_reset();
        m_busy = 0; m_is_inst = 0; m_killed = 0; m_waits = 0;
        e_access = 0; e_write = 0; e_iready = 0; e_dready = 0;
        e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0; e_size = 0; e_sel = 0;
    endtask

    task automatic model_step();
        bit fetch_wants, data_wants, take_fetch;
        if (!aresetn) begin
            model_reset();
            return;
        end
        fetch_wants = bus.inst_req && !e_iready;
        data_wants  = bus.data_req && !e_dready && !bus.flush;
        e_iready = 0;
        e_dready = 0;
        if (!m_busy) begin
            if (fetch_wants || data_wants) begin
                take_fetch = fetch_wants && (!data_wants || m_waits >= STARVE);
                m_busy = 1; m_killed = 0; m_is_inst = take_fetch; e_access = 1;
                if (take_fetch) begin
                    m_waits = 0;
                    e_addr = bus.inst_addr; e_write = 0; e_size = 2; e_sel = 4'hF; e_wdata = 0;
                end else begin
                    if (fetch_wants && m_waits < STARVE) m_waits++;
                    e_addr  = (bus.data_addr[31:16] == 16'hBFAF) ? bus.data_addr - 32'hA000_0000
                                                                 : bus.data_addr;
                    e_write = bus.data_wr; e_size = bus.data_size;
                    e_sel   = bus.data_sel; e_wdata = bus.data_wdata;
                end
            end
        end else if (m_killed) begin
            if (bus.mem_ready) m_busy = 0;
        end else if (bus.flush) begin
            e_access = 0;
            if (bus.mem_ready) m_busy = 0;
            else m_killed = 1;
        end else if (bus.mem_ready) begin
            e_access = 0;
            m_busy = 0;
            if (m_is_inst) begin
                e_iready = 1; e_irdata = bus.mem_data; m_inst_done++;
            end else begin
                e_dready = 1; e_drdata = bus.mem_data; m_data_done++;
            end
        end
    endtask

    // Bridge behaviour: one reply per transaction after 1..4 cycles, even if access was dropped.
    bit br_pending;
    int br_cnt;

    task automatic bridge_step();
        bit prev_ready;
        prev_ready = bus.mem_ready;
        bus.mem_ready = 1'b0;
        bus.mem_data  = $urandom;
        if (!aresetn) begin
            br_pending = 0;
        end else if (br_pending) begin
            br_cnt--;
            if (br_cnt == 0) begin
                bus.mem_ready = 1'b1;
                br_pending = 0;
            end
        end else if (e_access && !prev_ready) begin
            br_pending = 1;
            br_cnt = $urandom_range(1, 4);
        end
    endtask

    task automatic new_data_req();
        bus.data_req   = 1'b1;
        bus.data_addr  = ($urandom_range(0, 3) == 0) ? {16'hBFAF, 16'($urandom)} : $urandom;
        bus.data_wr    = 1'($urandom);
        bus.data_size  = 2'($urandom_range(0, 2));
        bus.data_sel   = 4'($urandom);
        bus.data_wdata = $urandom;
    endtask

    // Requester behaviour: hold until ready; in the ready cycle either drop or present a new one.
    task automatic cpu_step();
        int data_rate;
        if (!aresetn) begin
            bus.inst_req = 1'b0;
            bus.data_req = 1'b0;
            bus.flush    = 1'b0;
            return;
        end
        if (!bus.inst_req) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.inst_req  = 1'b1;
                bus.inst_addr = {$urandom} & 32'hFFFF_FFFC;
            end
        end else if (e_iready) begin
            if ($urandom_range(0, 1) == 0) bus.inst_addr = {$urandom} & 32'hFFFF_FFFC;
            else bus.inst_req = 1'b0;
        end
        // Early phase fetch-only, middle phase heavy back-to-back data to force starvation.
        data_rate = (cyc < 300) ? 0 : (cyc < 1200) ? 9 : 3;
        if (!bus.data_req) begin
            if (data_rate != 0 && $urandom_range(0, 9) < data_rate) new_data_req();
        end else if (e_dready) begin
            if (cyc < 1200 || $urandom_range(0, 1) == 0) new_data_req();
            else bus.data_req = 1'b0;
        end
        bus.flush = (cyc >= 1200 && $urandom_range(0, 7) == 0);
        if (bus.flush && $urandom_range(0, 1) == 0) bus.data_req = 1'b0;
    endtask

    task automatic compare_all();
        check("mem_access",  32'(bus.mem_access),  32'(e_access));
        check("mem_addr",    bus.mem_addr,         e_addr);
        check("mem_write",   32'(bus.mem_write),   32'(e_write));
        check("mem_size",    32'(bus.mem_size),    32'(e_size));
        check("mem_sel",     32'(bus.mem_sel),     32'(e_sel));
        check("mem_st_data", bus.mem_st_data,      e_wdata);
        check("inst_ready",  32'(bus.inst_ready),  32'(e_iready));
        check("data_ready",  32'(bus.data_ready),  32'(e_dready));
        check("inst_rdata",  bus.inst_rdata,       e_irdata);
        check("data_rdata",  bus.data_rdata,       e_drdata);
        check("stall_if",    32'(bus.stall_if),    32'(bus.inst_req & ~e_iready));
        check("stall_mem",   32'(bus.stall_mem),   32'(bus.data_req & ~e_dready));
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        m_inst_done = 0; m_data_done = 0; dut_inst_done = 0; dut_data_done = 0;
        br_pending = 0; br_cnt = 0;
        aresetn = 1'b0;
        bus.inst_req = 0; bus.inst_addr = 0; bus.data_req = 0; bus.data_wr = 0;
        bus.data_size = 0; bus.data_sel = 0; bus.data_addr = 0; bus.data_wdata = 0;
        bus.flush = 0; bus.mem_ready = 0; bus.mem_data = 0;
        model_reset();

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
            if (bus.inst_ready) dut_inst_done++;
            if (bus.data_ready) dut_data_done++;
            cyc = c + 1;
            // Reset at start and two mid-run pulses landing wherever the traffic happens to be.
            aresetn = !(cyc < 3 || cyc == 700 || cyc == 2100);
            bridge_step();
            cpu_step();
        end

        check("inst_ready_count", 32'(dut_inst_done), 32'(m_inst_done));
        check("data_ready_count", 32'(dut_data_done), 32'(m_data_done));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
